// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte buffer that feeds uart_tx.
//
// Writes land in a power-of-two circular buffer. Write requests are counted
// either once per rising edge of wr_strobe or once per clk cycle while it is high.
// A four-state drain FSM takes one entry per uart frame and hands it to uart_tx.
// The FSM is paced by the baud_x1 tick and uses tx_ready as the handshake.
//
// Parameters
//   DATA_WIDTH   entry / tx_data width
//   ADDR_WIDTH   depth = 2**ADDR_WIDTH
//   STROBE_EDGE  1: one write per rising edge of wr_strobe, 0: one per cycle
//   AFULL_LEVEL  afull threshold (count >= AFULL_LEVEL)
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   baud_x1              one-clk-wide baud tick
//   wr_data, wr_strobe   enqueue side
//   tx_ready             uart_tx idle flag
//   tx_data, tx_strobe   byte and start request to uart_tx
//   empty, full, afull   registered occupancy flags
//   count                registered occupancy (wptr - rptr)
//   overflow, ovf_clr    sticky dropped-write flag and its clear
//
// Optional build macro UART_FIFO_CRLF_EN makes the FIFO send 8'h0D before
// every queued 8'h0A. The macro has no effect unless DATA_WIDTH == 8.

module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned STROBE_EDGE = 1,
    parameter int unsigned AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  baud_x1,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_strobe,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_strobe,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [PTR_W-1:0]      wptr_d;
    logic [PTR_W-1:0]      rptr_d;
    logic [PTR_W-1:0]      count_d;
    logic                  wr_strobe_q;

    logic                  wr_req_c;
    logic                  wr_en_c;
    logic                  wr_drop_c;
    logic                  start_c;
    logic                  pop_c;
    logic                  insert_cr_c;
    logic [DATA_WIDTH-1:0] rd_entry_c;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic                  tx_strobe_d;

    // Write request qualification; the full check uses the pre-cycle flag.
    always_comb begin
        wr_req_c  = (STROBE_EDGE != 0) ? (wr_strobe & ~wr_strobe_q) : wr_strobe;
        wr_en_c   = wr_req_c & ~full;
        wr_drop_c = wr_req_c & full;
    end

    // Combinational read of the head entry.
    always_comb begin
        rd_entry_c = mem[rptr[ADDR_WIDTH-1:0]];
    end

    // A frame may start only on a tick with data queued and uart_tx idle.
    always_comb begin
        start_c = baud_x1 & ~empty & tx_ready;
    end

`ifdef UART_FIFO_CRLF_EN
    localparam bit CRLF_ACTIVE = (DATA_WIDTH == 8);

    logic cr_sent;

    // A queued LF is preceded by a CR frame that does not pop the buffer.
    always_comb begin
        insert_cr_c = CRLF_ACTIVE && !cr_sent && (rd_entry_c == DATA_WIDTH'(8'h0A));
    end

    // cr_sent records whether the last frame started was an inserted CR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cr_sent <= 1'b0;
        end else if (state == S_IDLE && start_c) begin
            cr_sent <= insert_cr_c;
        end
    end
`else
    always_comb begin
        insert_cr_c = 1'b0;
    end
`endif

    // Drain FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Drain FSM: next state.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (start_c)               state_d = S_STROBE;
            S_STROBE: if (baud_x1)               state_d = S_BUSY;
            S_BUSY:   if (baud_x1 && !tx_ready)  state_d = S_DONE;
            S_DONE:   if (baud_x1 && tx_ready)   state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    // Drain FSM: pop, next tx_data and next tx_strobe.
    always_comb begin
        pop_c       = 1'b0;
        tx_data_d   = tx_data;
        tx_strobe_d = tx_strobe;
        case (state)
            S_IDLE: begin
                if (start_c) begin
                    tx_strobe_d = 1'b1;
                    if (insert_cr_c) begin
                        tx_data_d = DATA_WIDTH'(8'h0D);
                    end else begin
                        tx_data_d = rd_entry_c;
                        pop_c     = 1'b1;
                    end
                end
            end
            S_STROBE: begin
                if (baud_x1) begin
                    tx_strobe_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Next pointers; count is their difference so both sides stay consistent.
    always_comb begin
        wptr_d  = wr_en_c ? (wptr + PTR_W'(1)) : wptr;
        rptr_d  = pop_c   ? (rptr + PTR_W'(1)) : rptr;
        count_d = wptr_d - rptr_d;
    end

    // Pointers, status flags and uart_tx outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            wr_strobe_q <= 1'b0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            afull       <= 1'b0;
            overflow    <= 1'b0;
            tx_data     <= '0;
            tx_strobe   <= 1'b0;
        end else begin
            wptr        <= wptr_d;
            rptr        <= rptr_d;
            wr_strobe_q <= wr_strobe;
            count       <= count_d;
            empty       <= (count_d == '0);
            full        <= (count_d == PTR_W'(DEPTH));
            afull       <= (count_d >= PTR_W'(AFULL_LEVEL));
            // A drop in the same cycle as a clear leaves the flag set.
            overflow    <= wr_drop_c | (overflow & ~ovf_clr);
            tx_data     <= tx_data_d;
            tx_strobe   <= tx_strobe_d;
        end
    end

    // Storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo.
// Instance A uses the default parameters with edge strobes.
// Instance B uses level strobes.
// Instance C has a depth of four and is used to wrap the pointers.
// A small uart_tx model captures each frame and holds tx_ready low for a fixed time.
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset_n;
    logic       baud_x1;

    logic [7:0] a_wr_data, b_wr_data, c_wr_data;
    logic       a_wr_strobe, b_wr_strobe, c_wr_strobe;
    logic       a_tx_ready, b_tx_ready, c_tx_ready;
    logic [7:0] a_tx_data, b_tx_data, c_tx_data;
    logic       a_tx_strobe, b_tx_strobe, c_tx_strobe;
    logic       a_empty, b_empty, c_empty;
    logic       a_full, b_full, c_full;
    logic       a_afull, b_afull, c_afull;
    logic [4:0] a_count, b_count;
    logic [2:0] c_count;
    logic       a_overflow, b_overflow, c_overflow;
    logic       a_ovf_clr, b_ovf_clr, c_ovf_clr;

    logic       a_model_en, c_model_en;
    int         a_busy, c_busy;
    logic [7:0] a_frames[$];
    logic [7:0] c_frames[$];
    logic [7:0] c_expect[$];

    int         checks;
    int         failures;

    uart_tx_fifo u_a (
        .clk(clk), .reset_n(reset_n), .baud_x1(baud_x1),
        .wr_data(a_wr_data), .wr_strobe(a_wr_strobe), .tx_ready(a_tx_ready),
        .tx_data(a_tx_data), .tx_strobe(a_tx_strobe), .empty(a_empty),
        .full(a_full), .afull(a_afull), .count(a_count),
        .overflow(a_overflow), .ovf_clr(a_ovf_clr)
    );

    uart_tx_fifo #(.STROBE_EDGE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .baud_x1(baud_x1),
        .wr_data(b_wr_data), .wr_strobe(b_wr_strobe), .tx_ready(b_tx_ready),
        .tx_data(b_tx_data), .tx_strobe(b_tx_strobe), .empty(b_empty),
        .full(b_full), .afull(b_afull), .count(b_count),
        .overflow(b_overflow), .ovf_clr(b_ovf_clr)
    );

    uart_tx_fifo #(.ADDR_WIDTH(2)) u_c (
        .clk(clk), .reset_n(reset_n), .baud_x1(baud_x1),
        .wr_data(c_wr_data), .wr_strobe(c_wr_strobe), .tx_ready(c_tx_ready),
        .tx_data(c_tx_data), .tx_strobe(c_tx_strobe), .empty(c_empty),
        .full(c_full), .afull(c_afull), .count(c_count),
        .overflow(c_overflow), .ovf_clr(c_ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick every fourth clk, plus the uart_tx models for A and C.
    initial begin
        int bcnt;
        bcnt = 0;
        baud_x1 = 1'b0;
        a_tx_ready = 1'b0;
        c_tx_ready = 1'b0;
        a_busy = 0;
        c_busy = 0;
        forever begin
            @(negedge clk);
            bcnt = (bcnt == 3) ? 0 : bcnt + 1;
            baud_x1 = (bcnt == 0);
            if (!a_model_en) begin
                a_tx_ready = 1'b0; a_busy = 0;
            end else if (a_busy != 0) begin
                a_busy = a_busy - 1;
            end else if (a_tx_strobe && a_tx_ready) begin
                a_frames.push_back(a_tx_data); a_tx_ready = 1'b0; a_busy = 20;
            end else begin
                a_tx_ready = 1'b1;
            end
            if (!c_model_en) begin
                c_tx_ready = 1'b0; c_busy = 0;
            end else if (c_busy != 0) begin
                c_busy = c_busy - 1;
            end else if (c_tx_strobe && c_tx_ready) begin
                c_frames.push_back(c_tx_data); c_tx_ready = 1'b0; c_busy = 20;
            end else begin
                c_tx_ready = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One edge-style write on instance 0 (A) or 2 (C); returns on a negedge.
    task automatic push(input int inst, input logic [7:0] d);
        if (inst == 0) begin a_wr_data = d; a_wr_strobe = 1'b1; end
        else begin c_wr_data = d; c_wr_strobe = 1'b1; end
        @(negedge clk);
        a_wr_strobe = 1'b0;
        c_wr_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_frames(input int inst, input int target, input int budget);
        int n;
        n = 0;
        while (((inst == 0) ? a_frames.size() : c_frames.size()) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait", (inst == 0) ? a_frames.size() : c_frames.size(), target);
    endtask

    initial begin
        int n;
        int base;
        checks = 0; failures = 0;
        reset_n = 1'b0;
        a_model_en = 1'b0; c_model_en = 1'b0;
        a_wr_data = '0; b_wr_data = '0; c_wr_data = '0;
        a_wr_strobe = 1'b0; b_wr_strobe = 1'b0; c_wr_strobe = 1'b0;
        a_ovf_clr = 1'b0; b_ovf_clr = 1'b0; c_ovf_clr = 1'b0;
        b_tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_tx_strobe", a_tx_strobe, 0);
        check("rst_tx_data", a_tx_data, 0);
        check("rst_count", a_count, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_afull", a_afull, 0);
        check("rst_overflow", a_overflow, 0);

        // Ordering: three bytes queued, then drained one frame at a time.
        push(0, 8'h41); push(0, 8'h42); push(0, 8'h43);
        check("ord_count3", a_count, 3);
        check("ord_empty0", a_empty, 0);
        a_model_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_frames(0, k, 400);
            check("ord_frame", a_frames[k-1], 8'h40 + 8'(k));
            check("ord_count", a_count, 3 - k);
        end
        check("ord_empty1", a_empty, 1);
        repeat (60) @(negedge clk);
        a_model_en = 1'b0;

        // Fill to full, then drop writes.
        for (int i = 0; i < 16; i++) begin
            push(0, 8'h10 + 8'(i));
            if (i == 12) check("afull_at13", a_afull, 0);
            if (i == 13) check("afull_at14", a_afull, 1);
        end
        check("full_count16", a_count, 16);
        check("full_flag", a_full, 1);
        check("full_no_ovf", a_overflow, 0);
        push(0, 8'hEE);
        check("ovf_set", a_overflow, 1);
        check("ovf_count16", a_count, 16);
        a_ovf_clr = 1'b1;
        @(negedge clk);
        a_ovf_clr = 1'b0;
        check("ovf_clr", a_overflow, 0);
        a_ovf_clr = 1'b1; a_wr_data = 8'hEF; a_wr_strobe = 1'b1;
        @(negedge clk);
        check("ovf_set_wins", a_overflow, 1);
        a_ovf_clr = 1'b0; a_wr_strobe = 1'b0;
        @(negedge clk);
        check("ovf_held_count", a_count, 16);
        a_ovf_clr = 1'b1;
        @(negedge clk);
        a_ovf_clr = 1'b0;
        a_model_en = 1'b1;
        wait_frames(0, 19, 2000);
        for (int i = 0; i < 16; i++) begin
            check("full_drain_frame", a_frames[3+i], 8'h10 + 8'(i));
        end
        check("drain_empty", a_empty, 1);
        check("drain_count", a_count, 0);
        check("drain_full", a_full, 0);
        repeat (60) @(negedge clk);
        a_model_en = 1'b0;

        // Strobe modes: five cycles high.
        a_wr_data = 8'h55; a_wr_strobe = 1'b1;
        b_wr_data = 8'h30; b_wr_strobe = 1'b1;
        repeat (5) @(negedge clk);
        a_wr_strobe = 1'b0; b_wr_strobe = 1'b0;
        @(negedge clk);
        check("edge_mode_count", a_count, 1);
        check("level_mode_count", b_count, 5);
        check("level_mode_afull", b_afull, 0);
        check("level_mode_full", b_full, 0);
        check("level_mode_empty", b_empty, 0);
        check("level_mode_ovf", b_overflow, 0);
        check("level_mode_strobe", b_tx_strobe, 0);
        check("level_mode_txdata", b_tx_data, 0);

        // Wrap-around on the depth-4 instance.
        for (int v = 0; v < 16; v++) begin
`ifdef UART_FIFO_CRLF_EN
            if (v == 10) c_expect.push_back(8'h0D);
`endif
            c_expect.push_back(8'(v));
        end
        for (int v = 0; v < 4; v++) push(2, 8'(v));
        check("wrap_full", c_full, 1);
        check("wrap_count4", c_count, 4);
        check("wrap_afull", c_afull, 1);
        check("wrap_empty0", c_empty, 0);
        c_model_en = 1'b1;
        for (int v = 4; v < 16; v++) begin
            n = 0;
            while (c_full && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("wrap_full_wait", c_full, 0);
            push(2, 8'(v));
        end
        wait_frames(2, c_expect.size(), 3000);
        for (int i = 0; i < c_expect.size(); i++) begin
            check("wrap_frame", c_frames[i], c_expect[i]);
        end
        check("wrap_no_ovf", c_overflow, 0);
        check("wrap_end_empty", c_empty, 1);
        check("wrap_end_count", c_count, 0);
        check("wrap_end_full", c_full, 0);

        // Asynchronous reset in the middle of STROBE with three entries queued.
        push(0, 8'h56); push(0, 8'h57);
        check("ar_count3_pre", a_count, 3);
        a_model_en = 1'b1;
        n = 0;
        while (!a_tx_strobe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ar_strobe_seen", a_tx_strobe, 1);
        a_wr_data = 8'h58; a_wr_strobe = 1'b1;
        @(negedge clk);
        a_wr_strobe = 1'b0;
        check("ar_mid_strobe", a_tx_strobe, 1);
        check("ar_mid_count", a_count, 3);
        check("ar_popped", a_frames[$], 8'h55);
        #1 reset_n = 1'b0;
        #1;
        check("ar_tx_strobe", a_tx_strobe, 0);
        check("ar_count", a_count, 0);
        check("ar_empty", a_empty, 1);
        base = a_frames.size();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("ar_no_frame", a_frames.size(), base);
        check("ar_post_count", a_count, 0);
        check("ar_post_strobe", a_tx_strobe, 0);

        // Line feed handling.
        push(0, 8'h0A);
`ifdef UART_FIFO_CRLF_EN
        wait_frames(0, base + 1, 400);
        check("crlf_cr", a_frames[base], 8'h0D);
        check("crlf_count_cr", a_count, 1);
        wait_frames(0, base + 2, 400);
        check("crlf_lf", a_frames[base+1], 8'h0A);
        check("crlf_count_lf", a_count, 0);
`else
        wait_frames(0, base + 1, 400);
        check("lf_frame", a_frames[base], 8'h0A);
        check("lf_count", a_count, 0);
        repeat (200) @(negedge clk);
        check("lf_single", a_frames.size(), base + 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
